// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-way round-robin mux arbiter.
// Optional hold limit is enabled with MUX_ARB_HOLD_LIMIT_EN.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam int HOLD_MAX_DEF = 8;
  localparam int HCW          = 8;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating ownership-length counter with a limit flag.
// Used by mux_rr_arbiter only when MUX_ARB_HOLD_LIMIT_EN is defined.
module mux_arb_hold_cnt
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic lim
);

  localparam logic [HCW-1:0] CMAX = HCW'(HOLD_MAX - 1);

  logic [HCW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lim = (cnt == CMAX);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered shared mux.
// Define MUX_ARB_HOLD_LIMIT_EN to force a handover after HOLD_MAX cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be within 2..255");
  end

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last_b;
  logic       sel_nxt;
  logic       force_sw;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic hold_lim;

  mux_arb_hold_cnt #(
    .HOLD_MAX(HOLD_MAX)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_nxt != state),
    .en   (state != IDLE),
    .lim  (hold_lim)
  );

  assign force_sw = hold_lim;
`else
  assign force_sw = 1'b0;
`endif

  // Owner keeps the path until it drops its request, or the limit trips.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == OWN_A: begin
        if (!req_a || (force_sw && req_b))
          state_nxt = req_b ? OWN_B : IDLE;
      end
      state == OWN_B: begin
        if (!req_b || (force_sw && req_a))
          state_nxt = req_a ? OWN_A : IDLE;
      end
      default: begin
        if (req_a && req_b)
          state_nxt = last_b ? OWN_A : OWN_B;
        else if (req_a)
          state_nxt = OWN_A;
        else if (req_b)
          state_nxt = OWN_B;
        else
          state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_nxt = sel;
    unique case (1'b1)
      state_nxt == OWN_A: sel_nxt = 1'b0;
      state_nxt == OWN_B: sel_nxt = 1'b1;
      default:            sel_nxt = sel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      sel       <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      out_valid <= (state_nxt != IDLE);
      if (state_nxt != IDLE) begin
        out    <= sel_nxt ? data_b : data_a;
        last_b <= (state_nxt == OWN_B);
      end
    end
  end

  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter against a queue-fed reference model.
// Model follows MUX_ARB_HOLD_LIMIT_EN when the build defines it.
module tb_mux_rr_arbiter;

  localparam int W  = 8;
  localparam int HM = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  typedef struct packed {
    logic         ga;
    logic         gb;
    logic         sel;
    logic         v;
    logic [W-1:0] out;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b;
  logic [W-1:0] data_a, data_b;
  logic         gnt_a, gnt_b, sel, out_valid;
  logic [W-1:0] out;

  int vectors = 0;
  int errors  = 0;

  exp_t sb_q[$];

  int           m_owner;
  int           m_last;
  int           m_run;
  logic         m_sel;
  logic [W-1:0] m_out;
  logic         m_v;

  mux_rr_arbiter #(
    .WIDTH   (W),
    .HOLD_MAX(HM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a.ga  = gnt_a;
    a.gb  = gnt_b;
    a.sel = sel;
    a.v   = out_valid;
    a.out = out;
    return a;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a = actual();
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got ga=%b gb=%b sel=%b v=%b out=%h, want ga=%b gb=%b sel=%b v=%b out=%h",
               name, $time, a.ga, a.gb, a.sel, a.v, a.out,
               e.ga, e.gb, e.sel, e.v, e.out);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_run   = 0;
    m_sel   = 1'b0;
    m_out   = '0;
    m_v     = 1'b0;
  endtask

  // Owner: 0 none, 1 A, 2 B; m_run counts cycles held by the current owner.
  task automatic model_step(input logic ra, input logic rb,
                            input logic [W-1:0] da, input logic [W-1:0] db);
    int  nxt;
    bit  mine, other, forced;
    if (m_owner == 0) begin
      if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
      else           nxt = 0;
    end else begin
      mine   = (m_owner == 1) ? ra : rb;
      other  = (m_owner == 1) ? rb : ra;
      forced = LIM && other && (m_run >= HM);
      if (mine && !forced) nxt = m_owner;
      else if (other)      nxt = 3 - m_owner;
      else                 nxt = 0;
    end
    if (nxt == 0)            m_run = 0;
    else if (nxt != m_owner) m_run = 1;
    else                     m_run++;
    if (nxt != 0) begin
      m_last = nxt;
      m_sel  = (nxt == 2);
      m_out  = m_sel ? db : da;
      m_v    = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    m_owner = nxt;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.ga  = (m_owner == 1);
    e.gb  = (m_owner == 2);
    e.sel = m_sel;
    e.v   = m_v;
    e.out = m_out;
    return e;
  endfunction

  task automatic cycle(input logic ra, input logic rb,
                       input logic [W-1:0] da, input logic [W-1:0] db,
                       input bit do_rst);
    @(negedge clk);
    if (do_rst) begin
      #1 rst_n = 1'b0;
      #1 compare("async_rst", '0);
      #2 rst_n = 1'b1;
      model_reset();
    end
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
    model_step(ra, rb, da, db);
    sb_q.push_back(model_exp());
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        compare("cycle", e);
      end
    end
  end

  initial begin : stim
    rst_n  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    model_reset();
    #12;
    compare("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cycle(1, 1, rnd(), rnd(), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, rnd(), rnd(), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, rnd(), rnd(), 0);
    for (int i = 0; i < 8; i++)
      cycle(1, 0, (i % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, rnd(), rnd(), 0);
    for (int i = 0; i < 12; i++) cycle(1, 1, rnd(), rnd(), 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, rnd(), rnd(), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, rnd(), rnd(), 0);
    cycle(1, 1, rnd(), rnd(), 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, rnd(), rnd(), 0);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            rnd(), rnd(), $urandom_range(0, 63) == 0);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
